// File: rtl/pcw_mouse_pkg.sv
// Shared types and constants for the PS/2 mouse receive path.
package pcw_mouse_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DATA   = 2'd1,
        ST_PARITY = 2'd2,
        ST_STOP   = 2'd3
    } frame_state_t;

    localparam int TOGGLE_BIT          = 24;
    localparam int SYNC_BIT            = 3;
    localparam int DEFAULT_FILTER_LEN  = 8;
    localparam int DEFAULT_TIMEOUT_CYC = 100000;

    // Eight data bits plus the parity bit must carry an odd number of ones.
    function automatic logic odd_parity_ok(input logic [7:0] data, input logic parity);
        return ^{data, parity};
    endfunction

endpackage

// File: rtl/ps2_frame_rx.sv
// Synchronises and deglitches the PS/2 lines and deframes one 11-bit byte at a time.
module ps2_frame_rx
    import pcw_mouse_pkg::*;
#(
    parameter int FILTER_LEN = DEFAULT_FILTER_LEN
) (
    input  logic       clk_sys,
    input  logic       reset,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    input  logic       abort,
    output logic [7:0] byte_data,
    output logic       byte_valid,
    output logic       byte_err,
    output logic       fall_edge,
    output logic       busy
);

    localparam int FCW = $clog2(FILTER_LEN + 1);

    logic [1:0] raw_vec;
    logic [1:0] sync_vec;

    assign raw_vec = {ps2_data, ps2_clk};

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_sync
            logic meta_reg;
            logic sync_reg;
            always_ff @(posedge clk_sys) begin
                if (reset) begin
                    meta_reg <= 1'b1;
                    sync_reg <= 1'b1;
                end else begin
                    meta_reg <= raw_vec[gi];
                    sync_reg <= meta_reg;
                end
            end
            assign sync_vec[gi] = sync_reg;
        end
    endgenerate

    logic           sync_clk;
    logic           sync_data;
    logic [FCW-1:0] filt_cnt_reg;
    logic           filt_clk_reg;
    logic           filt_clk_d_reg;

    assign sync_clk  = sync_vec[0];
    assign sync_data = sync_vec[1];

    // The counter tracks how long the synchronised clock has disagreed with the filtered one.
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            filt_cnt_reg   <= '0;
            filt_clk_reg   <= 1'b1;
            filt_clk_d_reg <= 1'b1;
        end else begin
            filt_clk_d_reg <= filt_clk_reg;
            if (sync_clk == filt_clk_reg) begin
                filt_cnt_reg <= '0;
            end else if (filt_cnt_reg == FCW'(FILTER_LEN - 1)) begin
                filt_clk_reg <= sync_clk;
                filt_cnt_reg <= '0;
            end else begin
                filt_cnt_reg <= filt_cnt_reg + 1'b1;
            end
        end
    end

    assign fall_edge = filt_clk_d_reg & ~filt_clk_reg;

    frame_state_t state_reg;
    frame_state_t state_next;
    logic [2:0]   bit_cnt_reg;
    logic [7:0]   shift_reg;
    logic         parity_reg;

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        if (abort) begin
            state_next = ST_IDLE;
        end else if (fall_edge) begin
            case (state_reg)
                ST_IDLE:   if (!sync_data) state_next = ST_DATA;
                ST_DATA:   if (bit_cnt_reg == 3'd7) state_next = ST_PARITY;
                ST_PARITY: state_next = ST_STOP;
                default:   state_next = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            bit_cnt_reg <= '0;
            shift_reg   <= '0;
            parity_reg  <= 1'b0;
        end else if (abort) begin
            bit_cnt_reg <= '0;
        end else if (fall_edge) begin
            case (state_reg)
                ST_IDLE:   bit_cnt_reg <= '0;
                ST_DATA: begin
                    shift_reg   <= {sync_data, shift_reg[7:1]};
                    bit_cnt_reg <= bit_cnt_reg + 1'b1;
                end
                ST_PARITY: parity_reg <= sync_data;
                default:   ;
            endcase
        end
    end

    logic stop_edge;
    logic frame_good;

    always_comb begin
        stop_edge  = (state_reg == ST_STOP) && fall_edge && !abort;
        frame_good = sync_data && odd_parity_ok(shift_reg, parity_reg);
        byte_valid = stop_edge && frame_good;
        byte_err   = stop_edge && !frame_good;
        busy       = (state_reg != ST_IDLE);
        byte_data  = shift_reg;
    end

endmodule

// File: rtl/ps2_mouse_packetizer.sv
// Assembles three received PS/2 bytes into a mouse packet with an inactivity abort.
module ps2_mouse_packetizer
    import pcw_mouse_pkg::*;
#(
    parameter int FILTER_LEN  = DEFAULT_FILTER_LEN,
    parameter int TIMEOUT_CYC = DEFAULT_TIMEOUT_CYC
) (
    input  logic        clk_sys,
    input  logic        reset,
    input  logic        ps2_clk,
    input  logic        ps2_data,
    output logic [24:0] ps2_mouse,
    output logic        frame_err
);

    localparam int TCW = $clog2(TIMEOUT_CYC + 1);

    logic [7:0]     byte_data;
    logic           byte_valid;
    logic           byte_err;
    logic           fall_edge;
    logic           busy;
    logic           abort;
    logic           counting;
    logic [TCW-1:0] idle_cnt_reg;
    logic [1:0]     byte_idx_reg;
    logic [7:0]     status_reg;
    logic [7:0]     x_reg;
    logic [24:0]    ps2_mouse_reg;
    logic           frame_err_reg;

    ps2_frame_rx #(
        .FILTER_LEN (FILTER_LEN)
    ) u_frame_rx (
        .clk_sys    (clk_sys),
        .reset      (reset),
        .ps2_clk    (ps2_clk),
        .ps2_data   (ps2_data),
        .abort      (abort),
        .byte_data  (byte_data),
        .byte_valid (byte_valid),
        .byte_err   (byte_err),
        .fall_edge  (fall_edge),
        .busy       (busy)
    );

    // An edge in the expiry cycle suppresses the abort; saturation prevents a repeat pulse.
    assign counting = busy || (byte_idx_reg != 2'd0);
    assign abort    = counting && !fall_edge && (idle_cnt_reg == TCW'(TIMEOUT_CYC - 1));

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            idle_cnt_reg <= '0;
        end else if (fall_edge) begin
            idle_cnt_reg <= '0;
        end else if (counting && (idle_cnt_reg != TCW'(TIMEOUT_CYC))) begin
            idle_cnt_reg <= idle_cnt_reg + 1'b1;
        end
    end

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            byte_idx_reg  <= 2'd0;
            status_reg    <= '0;
            x_reg         <= '0;
            ps2_mouse_reg <= '0;
            frame_err_reg <= 1'b0;
        end else begin
            frame_err_reg <= byte_err | abort;
            if (byte_err || abort) begin
                byte_idx_reg <= 2'd0;
            end else if (byte_valid) begin
                case (byte_idx_reg)
                    2'd0: begin
                        // A first byte without the always-one bit means we are out of step.
                        if (byte_data[SYNC_BIT]) begin
                            status_reg   <= byte_data;
                            byte_idx_reg <= 2'd1;
                        end
                    end
                    2'd1: begin
                        x_reg        <= byte_data;
                        byte_idx_reg <= 2'd2;
                    end
                    default: begin
                        ps2_mouse_reg <= {~ps2_mouse_reg[TOGGLE_BIT], byte_data, x_reg, status_reg};
                        byte_idx_reg  <= 2'd0;
                    end
                endcase
            end
        end
    end

    assign ps2_mouse = ps2_mouse_reg;
    assign frame_err = frame_err_reg;

endmodule

// File: tb/tb_ps2_mouse_packetizer.sv
// Scoreboard bench: bit-banged PS/2 frames, packet-level reference model, decoupled monitor.
module tb_ps2_mouse_packetizer;

    localparam int FL = 4;
    localparam int TO = 2000;

    logic        clk_sys = 1'b0;
    logic        reset = 1'b1;
    logic        ps2_clk = 1'b1;
    logic        ps2_data = 1'b1;
    logic [24:0] ps2_mouse;
    logic        frame_err;

    ps2_mouse_packetizer #(
        .FILTER_LEN  (FL),
        .TIMEOUT_CYC (TO)
    ) dut (
        .clk_sys   (clk_sys),
        .reset     (reset),
        .ps2_clk   (ps2_clk),
        .ps2_data  (ps2_data),
        .ps2_mouse (ps2_mouse),
        .frame_err (frame_err)
    );

    always #5 clk_sys = ~clk_sys;

    typedef struct {
        bit          is_err;
        logic [24:0] val;
    } exp_t;

    exp_t       exp_q[$];
    logic [7:0] pend[$];
    bit         model_tog = 1'b0;
    int         vectors = 0;
    int         miscompares = 0;
    logic       prev_tog = 1'b0;
    logic [23:0] prev_data = '0;

    task automatic cyc(input int n);
        repeat (n) @(posedge clk_sys);
        #1;
    endtask

    function automatic void expect_err();
        exp_t e;
        e.is_err = 1'b1;
        e.val    = '0;
        exp_q.push_back(e);
    endfunction

    // Reference: accepted bytes collect in a list; a packet is the first three after a sync byte.
    function automatic void model_byte(input logic [7:0] b, input bit ok);
        exp_t e;
        if (!ok) begin
            expect_err();
            pend.delete();
            return;
        end
        if (pend.size() == 0 && !b[3]) return;
        pend.push_back(b);
        if (pend.size() == 3) begin
            model_tog = ~model_tog;
            e.is_err  = 1'b0;
            e.val     = {model_tog, pend[2], pend[1], pend[0]};
            exp_q.push_back(e);
            pend.delete();
        end
    endfunction

    task automatic send_byte(input logic [7:0] b, input bit bad_par, input bit bad_stop, input bit glitch);
        logic [10:0] fr;
        logic        par;
        par = bad_par ? ^b : ~^b;
        fr  = {~bad_stop, par, b, 1'b0};
        model_byte(b, !bad_par && !bad_stop);
        for (int i = 0; i < 11; i++) begin
            ps2_data = fr[i];
            cyc(10);
            ps2_clk = 1'b0;
            cyc(10);
            if (glitch && i == 3) begin
                ps2_clk = 1'b1;
                cyc(FL - 1);
                ps2_clk = 1'b0;
            end
            cyc(10);
            ps2_clk = 1'b1;
            cyc(10);
            if (glitch && i == 6) begin
                ps2_clk = 1'b0;
                cyc(FL - 1);
                ps2_clk = 1'b1;
            end
            cyc(10);
        end
        ps2_data = 1'b1;
        cyc(60);
    endtask

    task automatic send_pkt(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c, input bit glitch);
        send_byte(a, 1'b0, 1'b0, glitch);
        send_byte(b, 1'b0, 1'b0, glitch);
        send_byte(c, 1'b0, 1'b0, glitch);
    endtask

    task automatic silence();
        if (pend.size() > 0) begin
            expect_err();
            pend.delete();
        end
        cyc(TO + 500);
    endtask

    task automatic check_event(input bit is_err);
        exp_t e;
        vectors++;
        if (exp_q.size() == 0) begin
            miscompares++;
            $display("FAIL unexpected_%s: got mouse=%h frame_err=%b, required no event",
                     is_err ? "err" : "pkt", ps2_mouse, frame_err);
        end else begin
            e = exp_q.pop_front();
            if (e.is_err != is_err || (!is_err && ps2_mouse !== e.val)) begin
                miscompares++;
                $display("FAIL %s: got err=%b mouse=%h, required err=%b mouse=%h",
                         is_err ? "frame_err" : "packet", is_err, ps2_mouse, e.is_err, e.val);
            end else begin
                $display("%0t: %s ok mouse=%h", $time, is_err ? "frame_err" : "packet", ps2_mouse);
            end
        end
    endtask

    always @(negedge clk_sys) begin
        if (reset) begin
            prev_tog  = ps2_mouse[24];
            prev_data = ps2_mouse[23:0];
        end else begin
            if (ps2_mouse[24] != prev_tog) begin
                check_event(1'b0);
            end else if (ps2_mouse[23:0] != prev_data) begin
                vectors++;
                miscompares++;
                $display("FAIL hold: mouse data changed to %h without toggle, required %h", ps2_mouse[23:0], prev_data);
            end
            if (frame_err) check_event(1'b1);
            prev_tog  = ps2_mouse[24];
            prev_data = ps2_mouse[23:0];
        end
    end

    initial begin
        logic [7:0] b;
        int         r;
        reset = 1'b1;
        cyc(5);
        vectors++;
        if (ps2_mouse !== 25'h0) begin
            miscompares++;
            $display("FAIL reset_mouse: got %h, required 0000000", ps2_mouse);
        end
        vectors++;
        if (frame_err !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_frame_err: got %b, required 0", frame_err);
        end
        reset = 1'b0;
        cyc(20);

        send_pkt(8'h08, 8'h05, 8'hFB, 1'b0);
        send_pkt(8'h09, 8'h00, 8'h00, 1'b0);
        send_byte(8'h05, 1'b0, 1'b0, 1'b0);
        send_pkt(8'h08, 8'h01, 8'h02, 1'b0);
        send_byte(8'h08, 1'b1, 1'b0, 1'b0);
        send_pkt(8'h08, 8'h10, 8'h20, 1'b0);
        send_byte(8'h08, 1'b0, 1'b0, 1'b0);
        send_byte(8'h03, 1'b0, 1'b0, 1'b0);
        silence();
        send_pkt(8'h0A, 8'h01, 8'h01, 1'b0);
        send_byte(8'h18, 1'b0, 1'b1, 1'b0);
        send_pkt(8'h08, 8'h05, 8'hFB, 1'b1);

        send_byte(8'h08, 1'b0, 1'b0, 1'b0);
        send_byte(8'h05, 1'b0, 1'b0, 1'b0);
        reset = 1'b1;
        cyc(3);
        vectors++;
        if (ps2_mouse !== 25'h0) begin
            miscompares++;
            $display("FAIL midreset_mouse: got %h, required 0000000", ps2_mouse);
        end
        reset = 1'b0;
        pend.delete();
        model_tog = 1'b0;
        cyc(20);
        send_pkt(8'h08, 8'hAA, 8'h55, 1'b0);

        for (int p = 0; p < 15; p++) begin
            for (int k = 0; k < 3; k++) begin
                b = 8'($urandom);
                if (k == 0) b[3] = ($urandom_range(0, 4) != 0);
                r = int'($urandom_range(0, 19));
                send_byte(b, r == 0, r == 1, 1'b0);
                if ($urandom_range(0, 29) == 0) silence();
            end
        end

        cyc(100);
        vectors++;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL leftover: got %0d pending expected events, required 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
